// File: rtl/seq_detect_param_if.sv
// Stream-side bundle for seq_detect_param: serial bit input, mode/clear controls,
// match pulse and saturating match count.
interface seq_detect_param_if #(
  parameter int CNT_W = 8
) ();
  logic             in_valid;
  logic             in;
  logic             overlap_en;
  logic             count_clr;
  logic             out;
  logic [CNT_W-1:0] match_count;

  modport master (
    output in_valid, in, overlap_en, count_clr,
    input  out, match_count
  );

  modport slave (
    input  in_valid, in, overlap_en, count_clr,
    output out, match_count
  );
endinterface

// File: rtl/seq_detect_param.sv
// Parametrised Mealy detector for a LEN-bit pattern with run-time overlap mode and saturating count.
// Define SEQ_DETECT_OUT_REG_EN to register the match pulse (one cycle later, glitch-free).
module seq_detect_param #(
  parameter int             LEN     = 4,
  parameter logic [LEN-1:0] PATTERN = 4'b1011,
  parameter int             CNT_W   = 8
) (
  input logic          clk,
  input logic          reset,
  seq_detect_param_if.slave bus
);

  localparam int               FW      = (LEN > 2) ? $clog2(LEN) : 1;
  localparam logic [FW-1:0]    FULL    = FW'(LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  generate
    if (LEN < 2 || LEN > 32) begin : g_len_chk
      $error("seq_detect_param: LEN=%0d outside legal range 2..32", LEN);
    end
  endgenerate

  logic [LEN-2:0]   hist, hist_nx, hist_sh;
  logic [FW-1:0]    fill, fill_nx;
  logic [LEN-1:0]   cand;
  logic             hit;
  logic [CNT_W-1:0] cnt;

  assign cand = {hist, bus.in};
  assign hit  = bus.in_valid && (fill == FULL) && (cand == PATTERN);

  // A 1-bit history has no older bits to keep, so it just takes the new bit.
  generate
    if (LEN == 2) begin : g_sh1
      assign hist_sh = bus.in;
    end else begin : g_shn
      assign hist_sh = {hist[LEN-3:0], bus.in};
    end
  endgenerate

  always_comb begin
    hist_nx = hist;
    fill_nx = fill;
    if (bus.in_valid) begin
      if (hit && !bus.overlap_en) begin
        hist_nx = '0;
        fill_nx = '0;
      end else begin
        hist_nx = hist_sh;
        fill_nx = (fill == FULL) ? fill : fill + FW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist <= '0;
      fill <= '0;
    end else begin
      hist <= hist_nx;
      fill <= fill_nx;
    end
  end

  // Clear wins over a coincident hit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                        cnt <= '0;
    else if (bus.count_clr)            cnt <= '0;
    else if (hit && (cnt != CNT_MAX))  cnt <= cnt + CNT_W'(1);
  end

  assign bus.match_count = cnt;

`ifdef SEQ_DETECT_OUT_REG_EN
  logic out_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) out_q <= 1'b0;
    else        out_q <= hit;
  end

  assign bus.out = out_q;
`else
  assign bus.out = hit;
`endif

endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
- Parametrised Mealy sequence detector; next generation of the fixed 2-bit-state overlap/non-overlap detectors.
- Detects an arbitrary LEN-bit pattern on a serial bit stream, qualified by in_valid.
- Overlap/non-overlap mode is selectable at run time.
- Keeps a saturating match counter for the stream-monitor logic that consumes it.

Parameters:
- LEN, 4, pattern length in bits; legal range 2..32.
- PATTERN, 4'b1011, pattern to detect, LEN bits wide; MSB is the oldest (first received) bit.
- CNT_W, 8, width of match_count.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
- in_valid  input  1  qualifies in; bits are consumed only on cycles where in_valid=1.
- in  input  1  serial data bit.
- overlap_en  input  1  1 = overlapping detection; 0 = non-overlapping; sampled every valid cycle.
- count_clr  input  1  synchronous clear of match_count.
- out  output  1  match pulse.
- match_count  output  CNT_W  saturating count of matches.

Behaviour:
- Reset (reset=0, asynchronous):
  - hist <= 0, fill <= 0, match_count <= 0.
  - out is 0 while reset is asserted and on the first cycle after release.
- State:
  - hist: LEN-1 bit history register; hist[0] is the newest bit.
  - fill: counts valid bits received, 0..LEN-1, saturating at LEN-1.
- Match condition (combinational):
  - cand = {hist, in}.
  - hit = in_valid && (fill == LEN-1) && (cand == PATTERN).
  - out = hit (Mealy): asserted in the same cycle as the final pattern bit, zero latency.
- Valid cycle (in_valid=1), at posedge:
  - If hit and overlap_en=0: hist <= 0, fill <= 0. The next match needs LEN fresh bits.
  - Otherwise: hist <= {hist[LEN-3:0], in}, fill <= min(fill+1, LEN-1).
  - For LEN=2, hist is 1 bit and is simply loaded with in.
- Idle cycle (in_valid=0): hist and fill hold; out=0. Gaps in the stream are transparent.
- match_count, at posedge:
  - count_clr=1: cleared to 0. Clear has priority over a simultaneous hit; result is 0.
  - Else if hit and match_count < 2^CNT_W-1: increment by 1.
  - At all-ones: hold (saturate, no wrap).
- A mode change on overlap_en takes effect at the next hit only. History already captured is never discarded by a mode change alone.
- Reset mid-pattern: partial history is lost. A match requires LEN new valid bits after release.
- Elaboration: the instance fails (via $error in a generate check) if LEN < 2 or LEN > 32.

Optional Feature:
- Macro: SEQ_DETECT_OUT_REG_EN.
- Defined:
  - out becomes a registered copy of hit; it pulses one cycle after the final pattern bit (Moore-style timing, glitch-free).
  - Reset value of the out register is 0.
  - match_count timing is unchanged.
- Undefined: out = hit combinationally, as described above.

Test Plan:
- LEN=4, PATTERN=1011, overlap_en=1, stream 1,0,1,1,0,1,1 (in_valid=1) -> out=1 on bits 4 and 7 only; match_count=2.
- Same stream with overlap_en=0 -> out=1 on bit 4 only. Appending 1,0,1,1 gives out=1 on bit 11; match_count=2.
- Stream 1,0 then 3 cycles in_valid=0 (in toggling), then 1,1 -> out=1 on the 4th valid bit; no pulse during the gap.
- CNT_W=2, overlap stream 1011011011011011 (5 matches) -> match_count sticks at 3. Then count_clr=1 in the same cycle as a hit -> match_count=0 next cycle.
- Feed 1,0,1, drop reset to 0 for 1 cycle mid-cycle (asynchronous), release, feed 1 -> no match. match_count and out are 0 immediately on reset assertion.
- With SEQ_DETECT_OUT_REG_EN defined, the first scenario repeated -> out pulses on the cycles after bits 4 and 7; match_count=2.
